sumador_serie_n: RTL and testbench

// - Parametrised multi-cycle adder/subtractor; successor to the 8-bit registered sumador.
// - Processes a WIDTH-bit operation SLICE bits per clock through one carry chain.
// - START/BUSY/DONE handshake; carry/borrow out and signed overflow reported.
// - Sits between operand registers and the datapath result bus; trades latency for area.

---
 rtl/sumador_serie_n_pkg.sv | 23 ++
 rtl/sumador_slice.sv | 21 ++
 rtl/sumador_serie_n.sv | 128 ++++++++++++
 tb/tb_sumador_serie_n.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sumador_serie_n_pkg.sv
// Shared definitions for the serial adder/subtractor: operation codes, FSM states,
// and slice-counter sizing.
package sumador_serie_n_pkg;

  typedef enum logic [1:0] {
    MODO_HOLD = 2'b00,
    MODO_ADD  = 2'b01,
    MODO_SUB  = 2'b10,
    MODO_CLR  = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  // Counter needs at least one bit even when a single slice covers the word.
  function automatic int unsigned cnt_width(input int unsigned nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/sumador_slice.sv
// Combinational SLICE-bit adder; c_msb is the carry into the top bit, used for
// signed-overflow detection.
module sumador_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0] sum;

  assign sum   = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  assign s     = sum[SLICE-1:0];
  assign co    = sum[SLICE];
  assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];

endmodule

// File: rtl/sumador_serie_n.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is pushed through one
// SLICE-bit carry chain, LSB slice first, with a START/BUSY/DONE handshake.
module sumador_serie_n
  import sumador_serie_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RCI,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int          NSL = WIDTH / SLICE;
  localparam int unsigned CW  = cnt_width(NSL);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, res, q_reg;
  logic             carry, sub_op, rco_reg, ovf_reg;
  logic             load, step, clear, last, is_sub;
  logic [SLICE-1:0] s_sl;
  logic             co_sl, cmsb_sl;

  assign last   = (cnt == CW'(NSL - 1));
  assign is_sub = (MODO == MODO_SUB);

  sumador_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_reg[cnt*SLICE +: SLICE]),
    .b     (b_reg[cnt*SLICE +: SLICE]),
    .ci    (carry),
    .s     (s_sl),
    .co    (co_sl),
    .c_msb (cmsb_sl)
  );

  // Partial sums collect in acc; Q only sees the completed word on the last slice.
  always_comb begin
    res = acc;
    res[cnt*SLICE +: SLICE] = s_sl;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    if (ENB) begin
      if (MODO == MODO_CLR) begin
        clear      = 1'b1;
        state_next = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_FIN: begin
            if (START && (MODO == MODO_ADD || MODO == MODO_SUB)) begin
              load       = 1'b1;
              state_next = ST_RUN;
            end else begin
              state_next = ST_IDLE;
            end
          end
          ST_RUN: begin
            step = 1'b1;
            if (last) state_next = ST_FIN;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Subtraction is folded in at capture time: B is inverted and the borrow-in
  // becomes an inverted carry-in, so the running datapath is always an add.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      sub_op  <= 1'b0;
      q_reg   <= '0;
      rco_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        q_reg   <= '0;
        rco_reg <= 1'b0;
        ovf_reg <= 1'b0;
      end else if (load) begin
        a_reg  <= A;
        b_reg  <= is_sub ? ~B : B;
        carry  <= is_sub ? ~RCI : RCI;
        sub_op <= is_sub;
        cnt    <= '0;
      end else if (step) begin
        carry <= co_sl;
        acc   <= res;
        if (last) begin
          q_reg   <= res;
          rco_reg <= sub_op ^ co_sl;
          ovf_reg <= co_sl ^ cmsb_sl;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign Q    = q_reg;
  assign RCO  = rco_reg;
  assign OVF  = ovf_reg;
  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_sumador_serie_n.sv
// Bench for sumador_serie_n: a 16/4 and an 8/8 instance share stimulus; an
// arithmetic transaction model is checked every cycle, plus directed literals.
module tb_sumador_serie_n;

  logic        clk = 1'b0;
  logic        rst_n, enb, start, rci;
  logic [1:0]  modo;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [15:0] q16;
  logic [7:0]  q8;
  logic        rco16, ovf16, busy16, done16;
  logic        rco8, ovf8, busy8, done8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sumador_serie_n #(.WIDTH(16), .SLICE(4)) dut16 (
    .CLK(clk), .RESET_N(rst_n), .ENB(enb), .MODO(modo), .START(start),
    .A(a16), .B(b16), .RCI(rci), .Q(q16), .RCO(rco16), .OVF(ovf16),
    .BUSY(busy16), .DONE(done16)
  );

  sumador_serie_n #(.WIDTH(8), .SLICE(8)) dut8 (
    .CLK(clk), .RESET_N(rst_n), .ENB(enb), .MODO(modo), .START(start),
    .A(a8), .B(b8), .RCI(rci), .Q(q8), .RCO(rco8), .OVF(ovf8),
    .BUSY(busy8), .DONE(done8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: index 0 = 16-bit/4 slices, index 1 = 8-bit/1 slice.
  int          wd[2]  = '{16, 8};
  int          nsl[2] = '{4, 1};
  int          rem[2] = '{0, 0};
  bit          fin[2] = '{0, 0};
  logic [15:0] qm[2]  = '{16'h0, 16'h0};
  bit          rcom[2] = '{0, 0};
  bit          ovfm[2] = '{0, 0};
  logic [15:0] la[2], lb[2];
  bit          lr[2], lsub[2];

  function automatic void compute(input int i);
    longint mask = (64'sd1 <<< wd[i]) - 1;
    longint half = 64'sd1 <<< (wd[i] - 1);
    longint ua   = longint'(la[i]) & mask;
    longint ub   = longint'(lb[i]) & mask;
    longint sa   = (ua >= half) ? ua - (half * 2) : ua;
    longint sb   = (ub >= half) ? ub - (half * 2) : ub;
    longint full, sr;
    if (lsub[i]) begin
      full    = ua - ub - longint'(lr[i]);
      sr      = sa - sb - longint'(lr[i]);
      rcom[i] = (ua < ub + longint'(lr[i]));
    end else begin
      full    = ua + ub + longint'(lr[i]);
      sr      = sa + sb + longint'(lr[i]);
      rcom[i] = (full > mask);
    end
    qm[i]   = 16'(full & mask);
    ovfm[i] = (sr >= half) || (sr < -half);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rem[i] = 0; fin[i] = 0; qm[i] = '0; rcom[i] = 0; ovfm[i] = 0;
      end else if (enb) begin
        if (modo == 2'b11) begin
          rem[i] = 0; fin[i] = 0; qm[i] = '0; rcom[i] = 0; ovfm[i] = 0;
        end else if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            compute(i);
            fin[i] = 1;
          end
        end else begin
          fin[i] = 0;
          if (start && (modo == 2'b01 || modo == 2'b10)) begin
            la[i]   = (i == 0) ? a16 : {8'h00, a8};
            lb[i]   = (i == 0) ? b16 : {8'h00, b8};
            lr[i]   = rci;
            lsub[i] = (modo == 2'b10);
            rem[i]  = nsl[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cycle_dut16", {12'h0, q16, rco16, ovf16, busy16, done16},
          {12'h0, qm[0], rcom[0], ovfm[0], rem[0] > 0, fin[0]});
    check("cycle_dut8", {20'h0, q8, rco8, ovf8, busy8, done8},
          {20'h0, qm[1][7:0], rcom[1], ovfm[1], rem[1] > 0, fin[1]});
  end

  task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        input logic r, input int sel, input int stall_at, output int cyc);
    logic d;
    modo = m; a16 = a; b16 = b; a8 = a[7:0]; b8 = b[7:0]; rci = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", (sel == 0) ? busy16 : busy8, 1);
    cyc = 0;
    d = 1'b0;
    while (!d && cyc < 30) begin
      if (cyc == stall_at) begin
        enb = 1'b0;
        repeat (2) @(negedge clk);
        enb = 1'b1;
        cyc += 2;
      end else begin
        @(negedge clk);
        cyc++;
      end
      d = (sel == 0) ? done16 : done8;
    end
    if (!d) check("done_timeout", 0, 1);
  endtask

  task automatic op_check(input string name, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic r, input int sel, input int stall_at,
                          input logic [15:0] eq, input logic erco, input logic eovf, input int ecyc);
    int cyc;
    run_op(m, a, b, r, sel, stall_at, cyc);
    check({name, "_q"},   (sel == 0) ? q16 : {8'h00, q8}, eq);
    check({name, "_rco"}, (sel == 0) ? rco16 : rco8, erco);
    check({name, "_ovf"}, (sel == 0) ? ovf16 : ovf8, eovf);
    check({name, "_lat"}, cyc, ecyc);
  endtask

  initial begin
    rst_n = 1'b0; enb = 1'b1; modo = 2'b00; start = 1'b0; rci = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {q16, rco16, ovf16, busy16, done16}, 20'h0);
    rst_n = 1'b1;
    @(negedge clk);

    op_check("add",     2'b01, 16'd17,   16'd3, 1'b0, 0, -1, 16'd20,   1'b0, 1'b0, 4);
    op_check("wrap",    2'b01, 16'hFFFF, 16'd1, 1'b0, 0, -1, 16'h0000, 1'b1, 1'b0, 4);
    op_check("ovf_add", 2'b01, 16'h7FFF, 16'd1, 1'b0, 0, -1, 16'h8000, 1'b0, 1'b1, 4);
    op_check("sub_pos", 2'b10, 16'd4,    16'd3, 1'b0, 0, -1, 16'd1,    1'b0, 1'b0, 4);
    op_check("sub_neg", 2'b10, 16'd3,    16'd8, 1'b0, 0, -1, 16'hFFFB, 1'b1, 1'b0, 4);
    op_check("sub_rci", 2'b10, 16'd5,    16'd5, 1'b1, 0, -1, 16'hFFFF, 1'b1, 1'b0, 4);
    op_check("stall",   2'b01, 16'd17,   16'd3, 1'b0, 0,  1, 16'd20,   1'b0, 1'b0, 6);

    // START with hold mode is ignored
    modo = 2'b00; a16 = 16'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_busy", busy16, 0);
    check("hold_q", q16, 16'd20);
    @(negedge clk);
    check("hold_done", done16, 0);

    // Clear mid-run aborts without DONE
    modo = 2'b01; a16 = 16'd40; b16 = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    modo = 2'b11;
    @(negedge clk);
    check("abort_q", q16, 16'h0);
    check("abort_busy", busy16, 0);
    modo = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done16, 0);
    end

    op_check("b2b_first",  2'b01, 16'd100,  16'd23, 1'b0, 0, -1, 16'd123, 1'b0, 1'b0, 4);
    op_check("b2b_second", 2'b10, 16'd1000, 16'd1,  1'b0, 0, -1, 16'd999, 1'b0, 1'b0, 4);

    // Asynchronous reset between edges, mid-run
    modo = 2'b01; a16 = 16'd7; b16 = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", {q16, rco16, ovf16, busy16, done16}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modo = 2'b00;
    @(negedge clk);

    op_check("w8_add",  2'b01, 16'd17,   16'd3, 1'b0, 1, -1, 16'd20,   1'b0, 1'b0, 1);
    op_check("w8_sub",  2'b10, 16'd3,    16'd8, 1'b0, 1, -1, 16'h00FB, 1'b1, 1'b0, 1);
    op_check("w8_wrap", 2'b01, 16'h00FF, 16'd1, 1'b0, 1, -1, 16'h0000, 1'b1, 1'b0, 1);
    op_check("w8_ovf",  2'b01, 16'h007F, 16'd1, 1'b0, 1, -1, 16'h0080, 1'b0, 1'b1, 1);
    op_check("w8_rci",  2'b10, 16'd5,    16'd5, 1'b1, 1, -1, 16'h00FF, 1'b1, 1'b0, 1);

    modo = 2'b00;
    repeat (6) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
